// File: rtl/ballot_controller.sv
// ballot_controller: runs one voter session at a time in front of the
// per-candidate vote counters. The officer arms the unit, one button must be
// held stable for HOLD_CYCLES samples to count, ambiguous presses are
// rejected, and each session can yield at most one vote.
//
// Output contract: cand_vote_valid is a one-hot, single-cycle pulse with no
// back-pressure. The vote-count block has no ready signal, so a vote counts
// in exactly the cycle its valid bit is high. vote_done rises in that same
// cycle. reject and timeout are single-cycle pulses. At most one of the
// three pulses is high in any cycle.
module ballot_controller #(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCKOUT_CYCLES = 100,
  parameter int CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             session_start,
  input  logic [3:0]       button,
  output logic [3:0]       cand_vote_valid,
  output logic             armed,
  output logic             vote_done,
  output logic             reject,
  output logic             timeout,
  output logic [CNT_W-1:0] voters_served,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  // One timer serves both the session timeout and the lockout interval.
  // It saturates, so it can never wrap back below a threshold it has passed.
  localparam int TMR_MAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCKOUT_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_SAT      = TMR_W'(TMR_MAX);
  localparam logic [HOLD_W-1:0] HOLD_TARGET  = HOLD_W'(HOLD_CYCLES);

  // Registered state and outputs
  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [3:0]         r_sel;
  logic [3:0]         r_cand;
  logic               r_vote_done;
  logic               r_reject;
  logic               r_timeout;
  logic               r_armed;
  logic [CNT_W-1:0]   r_served;

  // Next-state values
  state_t             w_next_state;
  logic [TMR_W-1:0]   w_timer_next;
  logic [HOLD_W-1:0]  w_hold_next;
  logic [3:0]         w_sel_next;
  logic [3:0]         w_cand_next;
  logic               w_vote_next;
  logic               w_reject_next;
  logic               w_timeout_next;
  logic [CNT_W-1:0]   w_served_next;

  // Button classification and helper arithmetic
  logic               w_btn_none;
  logic               w_btn_single;
  logic               w_btn_multi;
  logic [TMR_W-1:0]   w_timer_inc;
  logic [HOLD_W-1:0]  w_hold_inc;
  logic               w_abort;

  assign w_btn_none   = (button == 4'd0);
  assign w_btn_single = !w_btn_none && ((button & (button - 4'd1)) == 4'd0);
  assign w_btn_multi  = !w_btn_none && !w_btn_single;
  assign w_timer_inc  = (r_timer == TMR_SAT) ? r_timer : (r_timer + TMR_W'(1));
  assign w_hold_inc   = r_hold_cnt + HOLD_W'(1);
  assign w_abort      = mode && (r_state != ST_IDLE);

  // Next-state, timer, hold counter and pulse decisions for the session FSM
  always_comb begin
    w_next_state   = r_state;
    w_timer_next   = r_timer;
    w_hold_next    = r_hold_cnt;
    w_sel_next     = r_sel;
    w_cand_next    = 4'd0;
    w_vote_next    = 1'b0;
    w_reject_next  = 1'b0;
    w_timeout_next = 1'b0;
    w_served_next  = r_served;

    case (r_state)
      ST_IDLE: begin
        if (session_start && !mode) begin
          w_next_state = ST_ARMED;
          w_timer_next = '0;
          w_hold_next  = '0;
          w_sel_next   = 4'd0;
        end
      end

      ST_ARMED: begin
        w_timer_next = w_timer_inc;
        if (w_btn_single) begin
          if (HOLD_CYCLES == 1) begin
            // A single sample is enough: accept without visiting HOLD.
            w_cand_next   = button;
            w_vote_next   = 1'b1;
            w_served_next = r_served + CNT_W'(1);
            w_next_state  = ST_LOCKOUT;
            w_timer_next  = '0;
            w_hold_next   = '0;
          end else begin
            w_sel_next   = button;
            w_hold_next  = HOLD_W'(1);
            w_next_state = ST_HOLD;
          end
        end else if (w_btn_multi) begin
          w_reject_next = 1'b1;
          w_next_state  = ST_RELEASE;
        end else if (r_timer >= TIMEOUT_LAST) begin
          w_timeout_next = 1'b1;
          w_next_state   = ST_IDLE;
        end
      end

      ST_HOLD: begin
        // The timer is frozen while a candidate is being held.
        if (button == r_sel) begin
          if (w_hold_inc >= HOLD_TARGET) begin
            w_cand_next   = r_sel;
            w_vote_next   = 1'b1;
            w_served_next = r_served + CNT_W'(1);
            w_next_state  = ST_LOCKOUT;
            w_timer_next  = '0;
            w_hold_next   = '0;
          end else begin
            w_hold_next = w_hold_inc;
          end
        end else if (w_btn_none) begin
          w_hold_next  = '0;
          w_next_state = ST_ARMED;
        end else begin
          w_reject_next = 1'b1;
          w_hold_next   = '0;
          w_next_state  = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // A voter who never lets go still gets timed out.
        w_timer_next = w_timer_inc;
        if (r_timer >= TIMEOUT_LAST) begin
          w_timeout_next = 1'b1;
          w_next_state   = ST_IDLE;
        end else if (w_btn_none) begin
          w_next_state = ST_ARMED;
        end
      end

      ST_LOCKOUT: begin
        // A held button keeps the unit here until it is let go.
        w_timer_next = w_timer_inc;
        if ((r_timer >= LOCKOUT_LAST) && w_btn_none) begin
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
        w_timer_next = '0;
        w_hold_next  = '0;
        w_sel_next   = 4'd0;
      end
    endcase

    // Switching to result display drops the session silently.
    if (w_abort) begin
      w_next_state   = ST_IDLE;
      w_timer_next   = '0;
      w_hold_next    = '0;
      w_sel_next     = 4'd0;
      w_cand_next    = 4'd0;
      w_vote_next    = 1'b0;
      w_reject_next  = 1'b0;
      w_timeout_next = 1'b0;
      w_served_next  = r_served;
    end
  end

  // State register, counters and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_hold_cnt  <= '0;
      r_sel       <= 4'd0;
      r_cand      <= 4'd0;
      r_vote_done <= 1'b0;
      r_reject    <= 1'b0;
      r_timeout   <= 1'b0;
      r_armed     <= 1'b0;
      r_served    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_timer     <= w_timer_next;
      r_hold_cnt  <= w_hold_next;
      r_sel       <= w_sel_next;
      r_cand      <= w_cand_next;
      r_vote_done <= w_vote_next;
      r_reject    <= w_reject_next;
      r_timeout   <= w_timeout_next;
      r_armed     <= (w_next_state == ST_ARMED) || (w_next_state == ST_HOLD) ||
                     (w_next_state == ST_RELEASE);
      r_served    <= w_served_next;
    end
  end

  assign cand_vote_valid = r_cand;
  assign vote_done       = r_vote_done;
  assign reject          = r_reject;
  assign timeout         = r_timeout;
  assign armed           = r_armed;
  assign voters_served   = r_served;
  assign state           = r_state;

endmodule

// File: doc/ballot_controller.md
Name: ballot_controller

Overview:
- Sequences one voter session at a time in front of the per-candidate vote counters.
- Arms the ballot unit when the polling officer starts a session and qualifies the four raw candidate buttons with a hold-time filter.
- Rejects ambiguous multi-button presses and emits at most one single-cycle, one-hot vote-valid pulse per session.
- Sits between the front-panel buttons and the vote-count block; its cand_vote_valid bits drive that block's per-candidate valid inputs directly.

Parameters:
- HOLD_CYCLES, 4: consecutive cycles a single button must be sampled high before the vote is accepted. Must be ≥1.
- TIMEOUT_CYCLES, 1000: cycles a session may sit in ARMED/RELEASE without a vote before it is abandoned. Must be ≥2.
- LOCKOUT_CYCLES, 100: minimum cycles in LOCKOUT after an accepted vote. Must be ≥1.
- CNT_W, 8: width of voters_served.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- mode  in  1  0 = voting, 1 = result display; 1 aborts any session.
- session_start  in  1  officer pulse that opens a voter session.
- button  in  4  raw candidate buttons, bit i = candidate i+1, already synchronised.
- cand_vote_valid  out  4  one-hot, single-cycle accepted vote.
- armed  out  1  ready lamp; high in ARMED, HOLD, RELEASE.
- vote_done  out  1  single-cycle pulse, coincident with cand_vote_valid.
- reject  out  1  single-cycle pulse on a multi-button or changed press.
- timeout  out  1  single-cycle pulse when a session is abandoned.
- voters_served  out  CNT_W  count of accepted votes; wraps at 2^CNT_W.
- state  out  3  current state encoding, for debug.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at an edge): state=IDLE; every output 0; internal timer, hold counter and latched selection cleared. Reset overrides every other condition in the same cycle.
- States and encodings: IDLE=0, ARMED=1, HOLD=2, RELEASE=3, LOCKOUT=4. Unused encodings go to IDLE.
- Global abort: mode==1 in any non-IDLE state moves to IDLE next cycle. No vote, reject or timeout pulse is produced; voters_served is unchanged.
- IDLE:
  - session_start==1 && mode==0 → ARMED, timer cleared.
  - session_start is ignored in every other state.
- ARMED: timer increments each cycle.
  - button==0 and timer==TIMEOUT_CYCLES-1 → timeout pulse, go to IDLE.
  - popcount(button)==1 → latch sel=button, set hold count to 1, go to HOLD.
  - popcount(button)≥2 → reject pulse, go to RELEASE.
  - Button activity takes priority over timeout in the same cycle.
- HOLD: timer is frozen.
  - button==sel: increment hold count. When the sample makes HOLD_CYCLES consecutive matches (counting the ARMED entry sample):
    - cand_vote_valid=sel and vote_done=1 for exactly the next cycle;
    - voters_served increments, wrapping from max to 0;
    - go to LOCKOUT, timer cleared.
  - If HOLD_CYCLES==1, acceptance happens straight from ARMED on the first single-press sample.
  - button==0 → back to ARMED; no pulse; timer resumes.
  - Any other value → reject pulse, go to RELEASE.
- RELEASE: timer continues from its current value.
  - Wait for button==0, then go to ARMED.
  - Timeout applies as in ARMED: timer==TIMEOUT_CYCLES-1 → timeout pulse, go to IDLE.
- LOCKOUT: timer counts.
  - Exit to IDLE only when timer≥LOCKOUT_CYCLES-1 AND button==0. A held button extends LOCKOUT indefinitely.
  - Prevents a second vote in the same session.
- Latency: with the button stable from the first ARMED sample at edge t0, cand_vote_valid is high in the cycle after edge t0+HOLD_CYCLES-1.
- Output exclusivity: at most one of vote_done/reject/timeout is high in any cycle, and cand_vote_valid is never multi-hot.

Test Plan (HOLD_CYCLES=4, TIMEOUT_CYCLES=20, LOCKOUT_CYCLES=8):
- Hold reset=0 for 3 cycles with random inputs → all outputs 0, state=0. Release reset, pulse session_start with mode=0 → armed=1 next cycle, state=1.
- Armed; button=4'b0010 held 10 cycles → exactly one cycle of cand_vote_valid=4'b0010 plus vote_done, 4 cycles after the first sample. voters_served 0→1, state=4, armed=0.
- Armed; button=4'b0101 → reject pulse, state=3. Release to 0, then press 4'b1000 for 4 cycles → single cand_vote_valid=4'b1000.
- Armed; press 4'b0001 for 2 cycles, release, stay idle → no vote. Timeout pulse and state=0 once the ARMED/RELEASE timer reaches 19.
- Vote accepted while button stays held 30 cycles → remains in LOCKOUT, no second pulse. After release → IDLE. A session_start pulsed during LOCKOUT is ignored.
- mode=1 asserted in HOLD → IDLE next cycle, no pulses. Preload 255 accepted votes, then one more → voters_served=0 (wrap).
